skew_buffer: RTL
================

Name: skew_buffer

Overview:
- Parametrised successor to the loop-addressed shift buffer. Converts a stream of WIDTH-lane vectors into a diagonally skewed stream (lane j delayed j beats) or a de-skewed stream (lane j delayed WIDTH-1-j beats), in the format a systolic array expects.
- Sits between the global buffer and the PE array on the operand path, and on the result path for de-skew.
- Packet-aware: after the last input beat, the block drains WIDTH-1 pad beats so every element leaves the block. The final output beat is tagged with dout_last.

Parameters:
- DATA_WIDTH, 8, bits per lane element.
- WIDTH, 32, number of lanes; must be >= 1.
- PAD_VAL, 0, DATA_WIDTH-bit value emitted in positions with no valid element.
- CNT_WIDTH, $clog2(WIDTH)+1, width of the drain counter.

Ports:
- clk  input  1  clock.
- Rst  input  1  synchronous active-high reset.
- mode  input  2  delay mode, sampled on the first beat of each packet: 2'b00 skew, 2'b01 de-skew, 2'b10 bypass (see Optional Feature); 2'b11 behaves as skew.
- din  input  WIDTH*DATA_WIDTH  input vector; lane j is bits [j*DATA_WIDTH +: DATA_WIDTH].
- din_vld  input  1  input valid.
- din_last  input  1  marks the last beat of a packet.
- din_rdy  output  1  input ready.
- dout  output  WIDTH*DATA_WIDTH  skewed output vector.
- dout_vld  output  1  output valid.
- dout_last  output  1  marks the last output beat of a packet.
- dout_rdy  input  1  output ready.
- busy  output  1  high in STREAM or DRAIN.
- drain_cnt  output  CNT_WIDTH  pad beats remaining in DRAIN.

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high on Rst, and is the only reset.
- Reset values:
  - dout_vld = 0, dout_last = 0, dout = all PAD_VAL.
  - busy = 0, drain_cnt = 0, state = IDLE.
  - All delay-line registers = PAD_VAL; latched mode = skew.
- Rst asserted mid-packet or mid-DRAIN: all reset values apply on the next edge, and the pending output beat is discarded.
- Delay per lane:
  - Skew: d_j = j.
  - De-skew: d_j = WIDTH-1-j.
  - Bypass: d_j = 0.
- Storage: one shift register per lane, depth WIDTH-1 (none when WIDTH = 1); tap at d_j-1; a lane with d_j = 0 passes din directly.
- Output slot is one register. adv = !dout_vld | dout_rdy.
- Transfer function: output beat n, lane j = input beat (n-d_j), lane j, or PAD_VAL if that beat is < 0 or beyond the packet. A packet of N input beats yields N+WIDTH-1 output beats (N in bypass or when WIDTH = 1).
- State machine:
  - IDLE: din_rdy = adv. On din_vld & din_rdy: latch mode, load the output register, shift the delay lines.
    - If din_last and the drain length D = max(d_j) is 0: set dout_last, stay in IDLE.
    - Else if din_last: go to DRAIN with drain_cnt = D.
    - Else: go to STREAM.
  - STREAM: din_rdy = adv. Each accepted beat loads the output register and shifts the delay lines. On accept with din_last, go to DRAIN (drain_cnt = D), or to IDLE with dout_last if D = 0.
  - DRAIN: din_rdy = 0. On each adv cycle, shift PAD_VAL into every lane, load the output register and decrement drain_cnt. The beat loaded with drain_cnt = 1 sets dout_last; then go to IDLE.
- Latency: an accepted beat appears on dout the next cycle. Throughput is 1 beat/cycle with no bubble between the end of DRAIN and the next packet's first beat.
- Backpressure: while dout_vld & !dout_rdy, dout, dout_vld, dout_last, delay lines and drain_cnt all hold, and din_rdy = 0.
- Mode changes mid-packet are ignored. After DRAIN, every delay line holds only PAD_VAL, because WIDTH-1 pads have been pushed; packets in any mode can therefore follow back-to-back.
- A din_last received while din_vld = 0 is ignored.

Optional Feature:
- Macro: SKEW_BYPASS_EN.
- Defined: mode 2'b10 selects bypass (all d_j = 0, no DRAIN, dout_last on the same beat as din_last, 1-cycle latency).
- Undefined: 2'b10 is treated as skew; the bypass mux is not synthesised.

Test Plan:
- Skew, WIDTH=4, PAD_VAL=0, 3 beats, element(k,j) = 16*(k+1)+j, dout_rdy=1. Required 6 output beats, lanes 0..3:
  - {10,0,0,0}
  - {20,11,0,0}
  - {30,21,12,0}
  - {0,31,22,13}
  - {0,0,32,23}
  - {0,0,0,33}, with dout_last on beat 5 only.
- De-skew, same input: beat0 = {0,0,0,13}, beat5 = {30,0,0,0}, dout_last on beat 5; din_rdy = 0 for 3 cycles during DRAIN.
- Same skew packet with dout_rdy toggling 1,0,0,1,...: output sequence identical to the first scenario; dout held stable while stalled; no input accepted while stalled.
- Back-to-back skew packet then de-skew packet with no idle cycle: second packet output matches its isolated result and contains no residue from the first.
- Rst pulsed at drain_cnt = 2: next cycle dout_vld = 0, busy = 0, drain_cnt = 0; a following 1-beat skew packet gives {10,0,0,0}...{0,0,0,13} with dout_last on the 4th beat.
- With SKEW_BYPASS_EN, mode=2'b10, 2 beats: output = input one cycle later, dout_last on beat 1, no DRAIN.

Source files
------------

// File: rtl/skew_buffer_if.sv
// Stream handshake bundle for skew_buffer: input beats, output beats and the per-packet mode select.
// The slave modport is the buffer's view; the master modport is the producer/consumer side.
interface skew_buffer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int WIDTH      = 32
);
    logic [1:0]                  mode;
    logic [WIDTH*DATA_WIDTH-1:0] din;
    logic                        din_vld;
    logic                        din_last;
    logic                        din_rdy;
    logic [WIDTH*DATA_WIDTH-1:0] dout;
    logic                        dout_vld;
    logic                        dout_last;
    logic                        dout_rdy;

    modport master (
        output mode, din, din_vld, din_last, dout_rdy,
        input  din_rdy, dout, dout_vld, dout_last
    );

    modport slave (
        input  mode, din, din_vld, din_last, dout_rdy,
        output din_rdy, dout, dout_vld, dout_last
    );
endinterface

// File: rtl/skew_buffer.sv
// skew_buffer: per-lane delay lines that skew (lane j late by j beats) or de-skew (late by WIDTH-1-j)
// a WIDTH-lane stream, then drain WIDTH-1 pad beats per packet. Define SKEW_BYPASS_EN to enable mode 2'b10 bypass.
//   state  | meaning
//   IDLE   | waiting for the first beat of a packet; mode is latched on its acceptance
//   STREAM | accepting the remaining beats of the packet
//   DRAIN  | pushing PAD_VAL beats until every lane has emptied; input stalled
module skew_buffer #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    WIDTH      = 32,
    parameter logic [DATA_WIDTH-1:0] PAD_VAL    = '0,
    parameter int                    CNT_WIDTH  = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 Rst,
    skew_buffer_if.slave         bus,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] drain_cnt
);
    localparam int                   DEPTH   = (WIDTH > 1) ? WIDTH - 1 : 1;
    localparam logic [CNT_WIDTH-1:0] MAX_DLY = CNT_WIDTH'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t                      state, state_nxt;
    logic [1:0]                  mode_q, eff_mode;
    logic                        eff_deskew, eff_bypass;
    logic                        adv, din_rdy, shift_en, last_beat, load_drain;
    logic [CNT_WIDTH-1:0]        drain_len;
    logic [WIDTH*DATA_WIDTH-1:0] in_vec, out_nxt, dout_q;
    logic                        dout_vld_q, dout_last_q;

    // First beat of a packet uses the live mode; later beats and the drain use the latched one.
    assign eff_mode   = (state == IDLE) ? bus.mode : mode_q;
    assign eff_deskew = (eff_mode == 2'b01);
`ifdef SKEW_BYPASS_EN
    assign eff_bypass = (eff_mode == 2'b10);
`else
    assign eff_bypass = 1'b0;
`endif
    assign drain_len  = eff_bypass ? '0 : MAX_DLY;
    assign adv        = !dout_vld_q || bus.dout_rdy;
    assign in_vec     = (state == DRAIN) ? {WIDTH{PAD_VAL}} : bus.din;

    always_ff @(posedge clk) begin
        if (Rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        din_rdy    = 1'b0;
        shift_en   = 1'b0;
        last_beat  = 1'b0;
        load_drain = 1'b0;
        case (state)
            IDLE, STREAM: begin
                din_rdy = adv;
                if (bus.din_vld && adv) begin
                    shift_en = 1'b1;
                    if (!bus.din_last) begin
                        state_nxt = STREAM;
                    end else if (drain_len == '0) begin
                        last_beat = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        load_drain = 1'b1;
                        state_nxt  = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (adv) begin
                    shift_en = 1'b1;
                    if (drain_cnt == CNT_WIDTH'(1)) begin
                        last_beat = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            mode_q      <= 2'b00;
            drain_cnt   <= '0;
            dout_q      <= {WIDTH{PAD_VAL}};
            dout_vld_q  <= 1'b0;
            dout_last_q <= 1'b0;
        end else begin
            if (state == IDLE && shift_en) mode_q <= bus.mode;
            if (load_drain)                       drain_cnt <= drain_len;
            else if (state == DRAIN && shift_en)  drain_cnt <= drain_cnt - CNT_WIDTH'(1);
            if (adv) begin
                dout_vld_q  <= shift_en;
                dout_last_q <= last_beat;
                if (shift_en) dout_q <= out_nxt;
            end
        end
    end

    for (genvar j = 0; j < WIDTH; j++) begin : g_lane
        localparam logic [CNT_WIDTH-1:0] SKEW_D   = CNT_WIDTH'(j);
        localparam logic [CNT_WIDTH-1:0] DESKEW_D = CNT_WIDTH'(WIDTH - 1 - j);

        logic [DATA_WIDTH-1:0] lane_in, lane_out;
        logic [CNT_WIDTH-1:0]  dly;

        assign lane_in = in_vec[j*DATA_WIDTH +: DATA_WIDTH];
        assign dly     = eff_bypass ? '0 : (eff_deskew ? DESKEW_D : SKEW_D);
        assign out_nxt[j*DATA_WIDTH +: DATA_WIDTH] = lane_out;

        if (WIDTH > 1) begin : g_dl
            logic [DATA_WIDTH-1:0] sr [DEPTH];

            // Tap d-1 holds the element accepted d beats before the current one.
            always_comb begin
                lane_out = lane_in;
                for (int k = 0; k < DEPTH; k++)
                    if (dly == CNT_WIDTH'(k + 1)) lane_out = sr[k];
            end

            always_ff @(posedge clk) begin
                if (Rst) begin
                    for (int k = 0; k < DEPTH; k++) sr[k] <= PAD_VAL;
                end else if (shift_en) begin
                    sr[0] <= lane_in;
                    for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
                end
            end
        end else begin : g_pass
            assign lane_out = lane_in;
        end
    end

    assign bus.din_rdy   = din_rdy;
    assign bus.dout      = dout_q;
    assign bus.dout_vld  = dout_vld_q;
    assign bus.dout_last = dout_last_q;
    assign busy          = (state != IDLE);
endmodule
